// File: rtl/sinegen_dds_mc_pkg.sv
// Shared definitions for the multi-channel DDS sine generator.
// Config register map, stage control bundle and quarter-wave table generator.
package sinegen_pkg;

    localparam logic [1:0] CFG_FTW = 2'd0;
    localparam logic [1:0] CFG_OFS = 2'd1;
    localparam logic [1:0] CFG_AMP = 2'd2;
    localparam logic [1:0] CFG_EN  = 2'd3;

    typedef struct packed {
        logic       q;
        logic [2:0] amp;
        logic       v;
    } sg_ctl_t;

    // Integer Taylor series in 60-bit fixed point so the table is
    // elaborated without real arithmetic and rounds exactly.
    function automatic logic [63:0] lut_val(input int aw, input int ow,
                                            input int i);
        logic [127:0] pi;
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] sum;
        logic [127:0] amp;
        pi   = 128'h3243F6A8885A308D;
        x    = (pi * 128'(2 * i + 1)) >> (aw + 2);
        x2   = (x * x) >> 60;
        term = x;
        sum  = x;
        for (int k = 1; k < 16; k++) begin
            term = ((term * x2) >> 60) / 128'((2 * k) * (2 * k + 1));
            if ((k % 2) == 1)
                sum = sum - term;
            else
                sum = sum + term;
        end
        amp = (128'd1 << (ow - 1)) - 128'd1;
        return 64'((sum * amp + (128'd1 << 59)) >> 60);
    endfunction

endpackage

// File: rtl/sinegen_dds_mc_if.sv
// Config write channel, phase sync and sample outputs of the DDS block.
interface sinegen_dds_mc_if #(
    parameter int NUM_CH  = 2,
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 20
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [CH_W-1:0]         cfg_ch;
    logic [1:0]              cfg_addr;
    logic [PHASE_W-1:0]      cfg_data;
    logic                    sync_phase;
    logic [NUM_CH*OUT_W-1:0] sine;
    logic [NUM_CH-1:0]       sine_valid;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_addr,
        output cfg_data,
        output sync_phase,
        input  cfg_ready,
        input  sine,
        input  sine_valid
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_addr,
        input  cfg_data,
        input  sync_phase,
        output cfg_ready,
        output sine,
        output sine_valid
    );

endinterface

// File: rtl/sinegen_dds_mc_qlut.sv
// Registered quarter-wave sine ROM, one read per cycle.
module sinegen_qlut
    import sinegen_pkg::*;
#(
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 20
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [LUT_AW-1:0] i_addr,
    output logic [OUT_W-2:0]  o_data
);

    localparam int DEPTH = 1 << LUT_AW;

    logic [OUT_W-2:0] w_rom [DEPTH];
    logic [OUT_W-2:0] r_data;

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic [OUT_W-2:0] LV =
            (OUT_W-1)'(lut_val(LUT_AW, OUT_W, i));
        assign w_rom[i] = LV;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_data <= '0;
        else
            r_data <= w_rom[i_addr];
    end

    assign o_data = r_data;

endmodule

// File: rtl/sinegen_dds_mc.sv
// Multi-channel DDS: per-channel phase accumulator, offset, quarter-wave
// lookup and arithmetic amplitude shift, three stages after the accumulator.
module sinegen_dds_mc
    import sinegen_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 8,
    parameter int OUT_W   = 20
) (
    input logic               i_clk,
    input logic               i_reset,
    sinegen_dds_mc_if.slave   bus
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TW   = LUT_AW + 2;
    localparam int SH   = PHASE_W - TW;

    logic r_rdy;
    logic w_wr;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_rdy <= 1'b0;
        else
            r_rdy <= 1'b1;
    end

    assign bus.cfg_ready = r_rdy;
    assign w_wr          = bus.cfg_valid && r_rdy;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [PHASE_W-1:0] r_acc;
        logic [PHASE_W-1:0] r_ftw;
        logic [PHASE_W-1:0] r_ofs;
        logic [2:0]         r_amp;
        logic               r_en;
        logic               w_sel;
        logic [TW-1:0]      w_top;
        logic [LUT_AW-1:0]  w_a;
        logic [LUT_AW-1:0]  r_a;
        sg_ctl_t            r_c1;
        sg_ctl_t            r_c2;
        logic [OUT_W-2:0]   w_m;
        logic [OUT_W-1:0]   w_mag;
        logic [OUT_W-1:0]   w_s;
        logic [OUT_W-1:0]   r_sine;
        logic               r_vld;

        assign w_sel = w_wr && (bus.cfg_ch == CH_W'(k));

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_ftw <= '0;
                r_ofs <= '0;
                r_amp <= '0;
                r_en  <= 1'b0;
            end else if (w_sel) begin
                unique case (bus.cfg_addr)
                    CFG_FTW: r_ftw <= bus.cfg_data;
                    CFG_OFS: r_ofs <= bus.cfg_data;
                    CFG_AMP: r_amp <= bus.cfg_data[2:0];
                    CFG_EN:  r_en  <= bus.cfg_data[0];
                endcase
            end
        end

        // Sync wins over increment and ignores the enable.
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset)
                r_acc <= '0;
            else if (bus.sync_phase)
                r_acc <= '0;
            else if (r_en)
                r_acc <= r_acc + r_ftw;
        end

        // Only quadrant and table index survive the offset add.
        assign w_top = TW'((r_acc + r_ofs) >> SH);
        assign w_a   = w_top[LUT_AW] ? ~w_top[LUT_AW-1:0]
                                     : w_top[LUT_AW-1:0];

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_a  <= '0;
                r_c1 <= '0;
            end else begin
                r_a      <= w_a;
                r_c1.q   <= w_top[TW-1];
                r_c1.amp <= r_amp;
                r_c1.v   <= r_en;
            end
        end

        sinegen_qlut #(
            .LUT_AW (LUT_AW),
            .OUT_W  (OUT_W)
        ) u_lut (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_addr  (r_a),
            .o_data  (w_m)
        );

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset)
                r_c2 <= '0;
            else
                r_c2 <= r_c1;
        end

        assign w_mag = {1'b0, w_m};
        assign w_s   = r_c2.q ? -w_mag : w_mag;

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_sine <= '0;
                r_vld  <= 1'b0;
            end else begin
                r_vld <= r_c2.v;
                if (r_c2.v)
                    r_sine <= $signed(w_s) >>> r_c2.amp;
            end
        end

        assign bus.sine[k*OUT_W +: OUT_W] = r_sine;
        assign bus.sine_valid[k]          = r_vld;
    end

endmodule

// File: doc/sinegen_dds_mc.md
Name: sinegen_dds_mc

Overview:
Multi-channel direct digital synthesis (DDS) sine generator with runtime-programmable frequency, phase offset and amplitude per channel. It replaces the fixed selector-driven sine generator in the ZCU106 signal path. Each channel has a phase accumulator followed by a pipelined quarter-wave ROM lookup. Outputs feed the DAC/ILA debug path.

Parameters:
NUM_CH, 2, number of independent channels
PHASE_W, 32, phase accumulator / tuning word width
LUT_AW, 8, quarter-wave ROM address width (2^LUT_AW entries)
OUT_W, 20, signed sample width per channel

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when high with cfg_valid
cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
cfg_addr  in  2  0=FTW, 1=phase offset, 2=amp_shift (low 3 bits), 3=enable (bit 0)
cfg_data  in  PHASE_W  write data
sync_phase  in  1  pulse: zero all accumulators on the same cycle
sine  out  NUM_CH*OUT_W  signed samples; channel k at [k*OUT_W +: OUT_W]
sine_valid  out  NUM_CH  per-channel sample valid

Behaviour:
- Reset (async assert, sync release): accumulators, FTW, offset, amp_shift and enable = 0; sine = 0; sine_valid = 0; cfg_ready = 0.
- cfg_ready rises one cycle after reset deasserts, then stays high. A write is accepted on any cycle where cfg_valid && cfg_ready. The register takes its new value at that edge. cfg_ch >= NUM_CH: write is accepted and ignored. cfg_addr 3 with bit0 = 0 disables the channel.
- Accumulator: acc <= acc + FTW (mod 2^PHASE_W) each cycle while enabled. When disabled, acc holds.
  - sync_phase has priority over increment: acc <= 0 for all channels in that cycle, regardless of enable.
  - A write of FTW takes effect on the next increment (no glitch; acc is never reset).
- Pipeline (per channel, 3 registered stages after acc):
  - S1: p = acc + offset; q = p[PHASE_W-1:PHASE_W-2]; a = p[PHASE_W-3 -: LUT_AW]; if q[0], a = ~a.
  - S2: m = lut[a] (registered ROM read); carry q[1].
  - S3: s = q[1] ? -m : m; sine = s >>> amp_shift (arithmetic shift).
- Latency: the acc value present at cycle t appears on sine at t+3.
- sine_valid[k] = enable[k] delayed 3 cycles, so valid asserts and deasserts aligned with the pipeline. When disabled, sine holds its last value.
- LUT contents: lut[i] = round((2^(OUT_W-1)-1) * sin(2*pi*(i+0.5)/(4*2^LUT_AW))), unsigned OUT_W-1 bits. The half-step offset gives exact mirror symmetry, no zero entry, and no overflow on negation.
- Wrap-around: accumulator overflow is silent modulo. Adding the offset also wraps modulo.
- Simultaneous sync_phase and cfg write: both take effect; the write lands and acc is zeroed.
- Reset mid-operation clears everything asynchronously, including pipeline contents.

Decomposition:
- Package sinegen_pkg holds:
  - cfg_addr constants CFG_FTW, CFG_OFS, CFG_AMP, CFG_EN;
  - the LUT generation function (LUT contents as a constant-function initial value).
- Sub-module sinegen_qlut: the registered quarter-wave ROM, parametrised by LUT_AW and OUT_W, instantiated once per channel.

Test Plan:
- Reset, no config -> sine = 0, sine_valid = 0, cfg_ready = 0 during reset and 1 from the first cycle after release.
- ch0 FTW = 2^30, enable -> repeating output sequence lut[0], lut[255], -lut[0], -lut[255] (lut[255] = 524285), with valid 3 cycles after enable.
- ch0 as above, offset = 2^30 -> sequence rotated by one sample (lut[255] first). ch1 left disabled -> sine_valid[1] = 0, ch1 output = 0.
- amp_shift = 2 on the running channel -> every sample equals the unshifted value >>> 2, negative values rounded toward -inf. Change lands 3 cycles after the write.
- Both channels enabled with different FTW, then pulse sync_phase -> 3 cycles later both channels output lut[0] together.
- Assert reset mid-stream while cfg_valid is high -> all outputs 0 immediately, the write is lost, and after release the channel stays disabled.
